// File: rtl/rob_update_arb_pkg.sv
// Shared constants for the ROB completion arbiter.
//   ROB_SZ  : number of ROB entries
//   ROB_IDX : width of a ROB index
//   ADDR_W  : width of a resolved branch address
//   wrap_add: (a + b) mod n for operands already below n
package rob_update_arb_pkg;

  localparam int ROB_SZ  = 32;
  localparam int ROB_IDX = $clog2(ROB_SZ);
  localparam int ADDR_W  = 64;

  // Operands are always < n, so a single conditional subtract replaces a
  // modulo that would otherwise synthesize a divider for non-power-of-2 n.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b,
                                           int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rob_update_arb_pick2.sv
// Round-robin pick of up to two requesters, purely combinational.
//   req    : request vector (one bit per slot)
//   ptr    : highest-priority slot this cycle
//   g1, g2 : first and second requesting slot at/after ptr, with wrap
//   found1 : g1 is valid; found2 : g2 is valid
//   gnt    : one-hot OR of g1 and g2
module rr_pick2
  import rob_update_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] g1,
  output logic [PW-1:0] g2,
  output logic          found1,
  output logic          found2,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] j;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    g1     = '0;
    g2     = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    gnt    = '0;
    j      = '0;
    // Walk slots in priority order ptr, ptr+1, ... ; each slot is visited
    // once, so g2 can never equal g1.
    for (int k = 0; k < N; k++) begin
      j = PW'(wrap_add(int'(ptr), k, N));
      if (req[j]) begin
        if (!found1) begin
          found1 = 1'b1;
          g1     = j;
          gnt[j] = 1'b1;
        end else if (!found2) begin
          found2 = 1'b1;
          g2     = j;
          gnt[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_update_arb.sv
// Completion arbiter between the functional units and the ROB update ports.
// Each FU owns a one-entry slot; up to two occupied slots drain per cycle in
// round-robin order. A branch miss discards every pending completion.
//   clk, reset       : clock and synchronous active-high reset
//   fu_valid         : FU i presents a completion
//   fu_rob_idx       : ROB index per FU, FU i at [i*ROB_IDX +: ROB_IDX]
//   fu_ba_ex         : branch address per FU, FU i at [i*64 +: 64]
//   fu_bt_ex         : branch-taken bit per FU
//   fu_rdy           : slot i can accept this cycle (combinational)
//   branch_miss      : ROB flush
//   up1_req/up2_req  : ROB update requests (port 2 only alongside port 1)
//   up_rob_idx*, up_ba_ex*, up_bt_ex* : update payloads, zero when idle
module rob_update_arb
  import rob_update_arb_pkg::*;
#(
  parameter  int NUM_FU = 4,
  localparam int PW     = $clog2(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*ROB_IDX-1:0] fu_rob_idx,
  input  logic [NUM_FU*ADDR_W-1:0] fu_ba_ex,
  input  logic [NUM_FU-1:0]        fu_bt_ex,
  output logic [NUM_FU-1:0]        fu_rdy,
  input  logic                     branch_miss,
  output logic                     up1_req,
  output logic                     up2_req,
  output logic [ROB_IDX-1:0]       up_rob_idx1,
  output logic [ROB_IDX-1:0]       up_rob_idx2,
  output logic [ADDR_W-1:0]        up_ba_ex1,
  output logic [ADDR_W-1:0]        up_ba_ex2,
  output logic                     up_bt_ex1,
  output logic                     up_bt_ex2
);

  logic [NUM_FU-1:0]  occ;
  logic [ROB_IDX-1:0] idx_q [NUM_FU];
  logic [ADDR_W-1:0]  ba_q  [NUM_FU];
  logic [NUM_FU-1:0]  bt_q;
  logic [PW-1:0]      rr_ptr;

  logic [PW-1:0]      g1, g2, last;
  logic               found1, found2;
  logic [NUM_FU-1:0]  gnt, gnt_eff, accept;
  logic               issue;

  rr_pick2 #(.N(NUM_FU)) u_pick (
    .req    (occ),
    .ptr    (rr_ptr),
    .g1     (g1),
    .g2     (g2),
    .found1 (found1),
    .found2 (found2),
    .gnt    (gnt)
  );

  // Nothing drains or enters while reset or a flush is in progress.
  assign issue   = !reset && !branch_miss;
  assign gnt_eff = gnt & {NUM_FU{issue}};
  assign fu_rdy  = {NUM_FU{issue}} & (~occ | gnt_eff);
  assign accept  = fu_valid & fu_rdy;
  assign last    = found2 ? g2 : g1;

  assign up1_req     = found1 && issue;
  assign up2_req     = found2 && issue;
  assign up_rob_idx1 = up1_req ? idx_q[g1] : '0;
  assign up_rob_idx2 = up2_req ? idx_q[g2] : '0;
  assign up_ba_ex1   = up1_req ? ba_q[g1]  : '0;
  assign up_ba_ex2   = up2_req ? ba_q[g2]  : '0;
  assign up_bt_ex1   = up1_req ? bt_q[g1]  : 1'b0;
  assign up_bt_ex2   = up2_req ? bt_q[g2]  : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ    <= '0;
      rr_ptr <= '0;
    end else if (branch_miss) begin
      occ    <= '0;
    end else begin
      // Accept wins over grant: a slot drained this cycle can refill.
      occ <= (occ & ~gnt_eff) | accept;
      if (up1_req) rr_ptr <= PW'(wrap_add(int'(last), 1, NUM_FU));
    end
  end

  // NOTE: payload storage is not reset; it is only ever read behind occ,
  // which is reset, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i]) begin
        idx_q[i] <= fu_rob_idx[i*ROB_IDX +: ROB_IDX];
        ba_q[i]  <= fu_ba_ex[i*ADDR_W +: ADDR_W];
        bt_q[i]  <= fu_bt_ex[i];
      end
    end
  end

endmodule

// File: tb/tb_rob_update_arb.sv
// Self-checking bench for rob_update_arb: a slot/queue reference model is
// compared against every DUT output each cycle, with directed scenarios
// pinning literal expectations and a randomized phase afterwards.
module tb_rob_update_arb;
  import rob_update_arb_pkg::*;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          fu_valid;
  logic [N*ROB_IDX-1:0]  fu_rob_idx;
  logic [N*ADDR_W-1:0]   fu_ba_ex;
  logic [N-1:0]          fu_bt_ex;
  logic [N-1:0]          fu_rdy;
  logic                  branch_miss;
  logic                  up1_req, up2_req;
  logic [ROB_IDX-1:0]    up_rob_idx1, up_rob_idx2;
  logic [ADDR_W-1:0]     up_ba_ex1, up_ba_ex2;
  logic                  up_bt_ex1, up_bt_ex2;

  rob_update_arb #(.NUM_FU(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .fu_valid    (fu_valid),
    .fu_rob_idx  (fu_rob_idx),
    .fu_ba_ex    (fu_ba_ex),
    .fu_bt_ex    (fu_bt_ex),
    .fu_rdy      (fu_rdy),
    .branch_miss (branch_miss),
    .up1_req     (up1_req),
    .up2_req     (up2_req),
    .up_rob_idx1 (up_rob_idx1),
    .up_rob_idx2 (up_rob_idx2),
    .up_ba_ex1   (up_ba_ex1),
    .up_ba_ex2   (up_ba_ex2),
    .up_bt_ex1   (up_bt_ex1),
    .up_bt_ex2   (up_bt_ex2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: per-slot contents plus the round-robin start slot.
  bit                 m_occ [N];
  logic [ROB_IDX-1:0] m_idx [N];
  logic [63:0]        m_ba  [N];
  bit                 m_bt  [N];
  int                 m_ptr = 0;

  // DUT outputs captured in the most recent cycle, for literal checks.
  logic               s_up1, s_up2, s_bt1, s_bt2;
  logic [ROB_IDX-1:0] s_idx1, s_idx2;
  logic [63:0]        s_ba1, s_ba2;
  logic [N-1:0]       s_rdy;

  task automatic set_fu(input int i, input bit v, input int idx,
                        input logic [63:0] ba, input bit bt);
    fu_valid[i]                       = v;
    fu_rob_idx[i*ROB_IDX +: ROB_IDX]  = ROB_IDX'(idx);
    fu_ba_ex[i*ADDR_W +: ADDR_W]      = ba;
    fu_bt_ex[i]                       = bt;
  endtask

  task automatic clear_inputs();
    fu_valid    = '0;
    fu_rob_idx  = '0;
    fu_ba_ex    = '0;
    fu_bt_ex    = '0;
    branch_miss = 1'b0;
  endtask

  // One clock: compare all outputs against the model mid-cycle, then
  // advance the model with the same inputs the DUT sees at the edge.
  task automatic cycle();
    int           q[$];
    bit           gr [N];
    bit           issue;
    logic [N-1:0] e_rdy;
    bit           e1, e2;
    @(negedge clk);
    issue = !reset && !branch_miss;
    for (int k = 0; k < N; k++)
      if (m_occ[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
    e1 = issue && q.size() >= 1;
    e2 = issue && q.size() >= 2;
    if (e1) gr[q[0]] = 1'b1;
    if (e2) gr[q[1]] = 1'b1;
    for (int i = 0; i < N; i++) e_rdy[i] = issue && (!m_occ[i] || gr[i]);

    check("fu_rdy",  fu_rdy,  e_rdy);
    check("up1_req", up1_req, e1);
    check("up2_req", up2_req, e2);
    check("up_rob_idx1", up_rob_idx1, e1 ? m_idx[q[0]] : '0);
    check("up_ba_ex1",   up_ba_ex1,   e1 ? m_ba[q[0]]  : '0);
    check("up_bt_ex1",   up_bt_ex1,   e1 ? m_bt[q[0]]  : 1'b0);
    check("up_rob_idx2", up_rob_idx2, e2 ? m_idx[q[1]] : '0);
    check("up_ba_ex2",   up_ba_ex2,   e2 ? m_ba[q[1]]  : '0);
    check("up_bt_ex2",   up_bt_ex2,   e2 ? m_bt[q[1]]  : 1'b0);

    s_up1 = up1_req;      s_up2 = up2_req;
    s_idx1 = up_rob_idx1; s_idx2 = up_rob_idx2;
    s_ba1 = up_ba_ex1;    s_ba2 = up_ba_ex2;
    s_bt1 = up_bt_ex1;    s_bt2 = up_bt_ex2;
    s_rdy = fu_rdy;

    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
      m_ptr = 0;
    end else if (branch_miss) begin
      for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) if (gr[i]) m_occ[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && e_rdy[i]) begin
          m_occ[i] = 1'b1;
          m_idx[i] = fu_rob_idx[i*ROB_IDX +: ROB_IDX];
          m_ba[i]  = fu_ba_ex[i*ADDR_W +: ADDR_W];
          m_bt[i]  = fu_bt_ex[i];
        end
      end
      if (e1) m_ptr = ((e2 ? q[1] : q[0]) + 1) % N;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1;
    cycle();
    cycle();
    check("reset_up1",  s_up1, 1'b0);
    check("reset_up2",  s_up2, 1'b0);
    check("reset_rdy",  s_rdy, 4'b0000);
    check("reset_ba1",  s_ba1, 64'h0);
    reset = 1'b0;

    // Single completion from FU2.
    set_fu(2, 1'b1, 5, 64'h1000, 1'b1);
    cycle();
    check("single_accept_rdy", s_rdy, 4'b1111);
    clear_inputs();
    cycle();
    check("single_up1",  s_up1,  1'b1);
    check("single_idx1", s_idx1, 5);
    check("single_ba1",  s_ba1,  64'h1000);
    check("single_bt1",  s_bt1,  1'b1);
    check("single_up2",  s_up2,  1'b0);
    check("single_rdy",  s_rdy,  4'b1111);

    // Wrap and skip: pointer is now 3, slots 1 and 3 occupied.
    set_fu(1, 1'b1, 1, 64'h11, 1'b0);
    set_fu(3, 1'b1, 3, 64'h33, 1'b1);
    cycle();
    clear_inputs();
    cycle();
    check("wrap_idx1", s_idx1, 3);
    check("wrap_idx2", s_idx2, 1);
    check("wrap_ba2",  s_ba2,  64'h11);
    // Pointer must now be 2: slot 2 ahead of slot 0.
    set_fu(0, 1'b1, 10, 64'hA0, 1'b0);
    set_fu(2, 1'b1, 12, 64'hC2, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("ptr2_idx1", s_idx1, 12);
    check("ptr2_idx2", s_idx2, 10);

    // Round-robin with all FUs valid every cycle.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) set_fu(i, 1'b1, i, 64'(c * 16 + i), 1'b0);
      cycle();
      if (c >= 1) begin
        check("rr_idx1", s_idx1, ((c - 1) % 2) * 2);
        check("rr_idx2", s_idx2, ((c - 1) % 2) * 2 + 1);
        check("rr_rdy",  s_rdy,  ((c - 1) % 2 == 0) ? 4'b0011 : 4'b1100);
      end else begin
        check("rr_first_rdy", s_rdy, 4'b1111);
      end
    end
    clear_inputs();

    // Back-pressure: slots 0..2 held valid; slot 2 must wait and hold data.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_fu(i, 1'b1, 16 + i, 64'h200 + 64'(i), 1'b0);
    cycle();
    set_fu(2, 1'b1, 30, 64'hDEAD, 1'b1);
    cycle();
    check("bp_rdy", s_rdy, 4'b1011);
    cycle();
    check("bp_idx1_held", s_idx1, 18);
    check("bp_ba1_held",  s_ba1,  64'h202);
    clear_inputs();
    cycle();
    cycle();

    // Flush with all slots occupied and new completions arriving.
    for (int i = 0; i < N; i++) set_fu(i, 1'b1, 8 + i, 64'h300 + 64'(i), 1'b1);
    cycle();
    branch_miss = 1'b1;
    cycle();
    check("flush_up1", s_up1, 1'b0);
    check("flush_up2", s_up2, 1'b0);
    check("flush_rdy", s_rdy, 4'b0000);
    clear_inputs();
    cycle();
    check("post_flush_up1", s_up1, 1'b0);

    // Reset mid-stream with a non-zero pointer.
    set_fu(0, 1'b1, 1, 64'h1, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    for (int i = 1; i < N; i++) set_fu(i, 1'b1, 4 + i, 64'h400 + 64'(i), 1'b0);
    cycle();
    reset = 1'b1;
    cycle();
    check("midrst_up1", s_up1, 1'b0);
    check("midrst_rdy", s_rdy, 4'b0000);
    reset = 1'b0;
    clear_inputs();
    set_fu(0, 1'b1, 20, 64'h500, 1'b0);
    set_fu(3, 1'b1, 23, 64'h503, 1'b0);
    cycle();
    check("midrst_empty_up1", s_up1, 1'b0);
    clear_inputs();
    cycle();
    check("midrst_first_slot0", s_idx1, 20);
    check("midrst_second",      s_idx2, 23);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(63) == 0);
      branch_miss = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++)
        set_fu(i, 1'($urandom_range(1)), int'($urandom_range(ROB_SZ - 1)),
               {$urandom, $urandom}, 1'($urandom_range(1)));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
